// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR controller slice: FSM state encoding and default tap mask.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } lfsr_state_e;

   localparam logic [7:0] LFSR_DEFAULT_TAPS = 8'h03;

endpackage

// File: rtl/lfsr_sr.sv
// Plain right-shifting register with a seed that is reloaded on synchronous reset.
module lfsr_sr #(
   parameter int unsigned      nbits = 8,
   parameter logic [nbits-1:0] seed  = nbits'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             shift_in,
   output logic [nbits-1:0] q
);

   logic [nbits-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst)
         r_q <= seed;
      else if (en)
         r_q <= {shift_in, r_q[nbits-1:1]};
   end

   assign q = r_q;

endmodule

// File: rtl/lfsr_top.sv
// Controller plus shift register, sharing clock and reset.
module lfsr_top
   import lfsr_pkg::*;
#(
   parameter int unsigned      nbits = 8,
   parameter int unsigned      cbits = 8,
   parameter logic [nbits-1:0] taps  = nbits'(LFSR_DEFAULT_TAPS),
   parameter logic [nbits-1:0] seed  = nbits'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [cbits-1:0] req_cnt,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [nbits-1:0] resp_q,
   output logic             resp_zero
);

   logic [nbits-1:0] w_sr_q;
   logic             w_sr_en;
   logic             w_sr_shift_in;

   lfsr_ctrl #(
      .nbits (nbits),
      .cbits (cbits),
      .taps  (taps)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .req_val     (req_val),
      .req_rdy     (req_rdy),
      .req_cnt     (req_cnt),
      .resp_val    (resp_val),
      .resp_rdy    (resp_rdy),
      .resp_q      (resp_q),
      .resp_zero   (resp_zero),
      .sr_q        (w_sr_q),
      .sr_en       (w_sr_en),
      .sr_shift_in (w_sr_shift_in)
   );

   lfsr_sr #(
      .nbits (nbits),
      .seed  (seed)
   ) u_sr (
      .clk      (clk),
      .rst      (rst),
      .en       (w_sr_en),
      .shift_in (w_sr_shift_in),
      .q        (w_sr_q)
   );

endmodule

// File: rtl/lfsr_ctrl.sv
// Step controller for an external Fibonacci LFSR: accepts "advance N steps" requests,
// pulses the register enable N times, then returns the resulting state.
module lfsr_ctrl
   import lfsr_pkg::*;
#(
   parameter int unsigned      nbits = 8,
   parameter int unsigned      cbits = 8,
   parameter logic [nbits-1:0] taps  = nbits'(LFSR_DEFAULT_TAPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [cbits-1:0] req_cnt,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [nbits-1:0] resp_q,
   output logic             resp_zero,
   input  logic [nbits-1:0] sr_q,
   output logic             sr_en,
   output logic             sr_shift_in
);

   lfsr_state_e      r_state;
   lfsr_state_e      w_state_nxt;
   logic [cbits-1:0] r_rem;
   logic [cbits-1:0] w_rem_nxt;
   logic             w_req_rdy;
   logic             w_sr_en;
   logic             w_resp_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_req_rdy   = 1'b0;
      w_sr_en     = 1'b0;
      w_resp_val  = 1'b0;
      case (r_state)
         IDLE: begin
            w_req_rdy = 1'b1;
            if (req_val) begin
               w_rem_nxt   = req_cnt;
               w_state_nxt = (req_cnt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            w_sr_en   = 1'b1;
            w_rem_nxt = r_rem - cbits'(1);
            if (r_rem <= cbits'(1))
               w_state_nxt = DONE;
         end
         DONE: begin
            w_resp_val = 1'b1;
            if (resp_rdy)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Handshake and enable outputs are forced low in the reset cycle itself,
   // so a register sharing rst reloads its seed without an extra shift.
   assign req_rdy     = w_req_rdy  & ~rst;
   assign sr_en       = w_sr_en    & ~rst;
   assign resp_val    = w_resp_val & ~rst;

   assign sr_shift_in = ^(sr_q & taps);
   assign resp_q      = sr_q;
   assign resp_zero   = (sr_q == '0);

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl with a behavioural shift register whose seed reloads on rst.
module tb_lfsr_ctrl;

   logic       clk;
   logic       rst;
   logic       req_val;
   logic       req_rdy;
   logic [7:0] req_cnt;
   logic       resp_val;
   logic       resp_rdy;
   logic [7:0] resp_q;
   logic       resp_zero;
   logic [7:0] sr_q;
   logic       sr_en;
   logic       sr_shift_in;
   logic [7:0] seed_v;

   int n_tests;
   int n_fail;

   lfsr_ctrl #(
      .nbits (8),
      .cbits (8),
      .taps  (8'h03)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_val     (req_val),
      .req_rdy     (req_rdy),
      .req_cnt     (req_cnt),
      .resp_val    (resp_val),
      .resp_rdy    (resp_rdy),
      .resp_q      (resp_q),
      .resp_zero   (resp_zero),
      .sr_q        (sr_q),
      .sr_en       (sr_en),
      .sr_shift_in (sr_shift_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rst)
         sr_q <= seed_v;
      else if (sr_en)
         sr_q <= {sr_shift_in, sr_q[7:1]};
   end

   task automatic do_reset(input logic [7:0] seed);
      @(negedge clk);
      seed_v = seed;
      rst    = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
   endtask

   // Issues one request and waits for resp_val; lat=-1 on timeout.
   task automatic transact(input logic [7:0] cnt, output int en_cnt, output int lat,
                           output logic [7:0] q, output logic z);
      en_cnt = 0;
      lat    = -1;
      q      = 8'hxx;
      z      = 1'bx;
      @(negedge clk);
      req_val = 1'b1;
      req_cnt = cnt;
      @(posedge clk);
      @(negedge clk);
      req_val = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         if (resp_val) begin
            lat = k;
            q   = resp_q;
            z   = resp_zero;
            break;
         end
         if (sr_en) en_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic finish_resp();
      resp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_rdy = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      seed_v = 8'h01;
      rst    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy got=%b exp=0", req_rdy); end
      n_tests++; if (sr_en !== 1'b0) begin n_fail++; $display("FAIL rst_sr_en got=%b exp=0", sr_en); end
      n_tests++; if (resp_val !== 1'b0) begin n_fail++; $display("FAIL rst_resp_val got=%b exp=0", resp_val); end
      n_tests++; if (resp_q !== 8'h01) begin n_fail++; $display("FAIL rst_resp_q got=%h exp=01", resp_q); end
      n_tests++; if (resp_zero !== 1'b0) begin n_fail++; $display("FAIL rst_resp_zero got=%b exp=0", resp_zero); end
      rst = 1'b0;
      #1;
      n_tests++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_req_rdy got=%b exp=1", req_rdy); end
      n_tests++; if (resp_val !== 1'b0 || sr_en !== 1'b0) begin n_fail++; $display("FAIL idle_outs got val=%b en=%b exp 0 0", resp_val, sr_en); end
   endtask

   task automatic test_steps(input string name, input logic [7:0] seed, input logic [7:0] cnt,
                             input logic [7:0] exp_q, input logic exp_z);
      int en_cnt, lat;
      logic [7:0] q;
      logic z;
      do_reset(seed);
      transact(cnt, en_cnt, lat, q, z);
      n_tests++; if (lat !== ((cnt == 0) ? 1 : int'(cnt) + 1)) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, (cnt == 0) ? 1 : int'(cnt) + 1); end
      n_tests++; if (en_cnt !== int'(cnt)) begin n_fail++; $display("FAIL %s_en_cycles got=%0d exp=%0d", name, en_cnt, cnt); end
      n_tests++; if (q !== exp_q) begin n_fail++; $display("FAIL %s_resp_q got=%h exp=%h", name, q, exp_q); end
      n_tests++; if (z !== exp_z) begin n_fail++; $display("FAIL %s_resp_zero got=%b exp=%b", name, z, exp_z); end
      finish_resp();
      n_tests++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin n_fail++; $display("FAIL %s_back_idle got rdy=%b val=%b exp 1 0", name, req_rdy, resp_val); end
   endtask

   task automatic test_backpressure();
      int en_cnt, lat;
      logic [7:0] q;
      logic z;
      do_reset(8'h01);
      transact(8'd1, en_cnt, lat, q, z);
      n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got=%0d exp=2", lat); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (resp_val !== 1'b1 || resp_q !== 8'h80 || sr_en !== 1'b0 || req_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d got val=%b q=%h en=%b rdy=%b exp 1 80 0 0", i, resp_val, resp_q, sr_en, req_rdy);
         end
      end
      finish_resp();
      n_tests++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin n_fail++; $display("FAIL bp_idle got rdy=%b val=%b exp 1 0", req_rdy, resp_val); end
   endtask

   task automatic test_reset_mid_shift();
      int en_cnt, lat;
      logic [7:0] q;
      logic z;
      do_reset(8'h01);
      @(negedge clk);
      req_val = 1'b1;
      req_cnt = 8'd10;
      @(posedge clk);
      @(negedge clk);
      req_val = 1'b0;
      n_tests++; if (sr_en !== 1'b1) begin n_fail++; $display("FAIL mid_shift1_en got=%b exp=1", sr_en); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++; if (sr_en !== 1'b0 || req_rdy !== 1'b0 || resp_val !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outs got en=%b rdy=%b val=%b exp 0 0 0", sr_en, req_rdy, resp_val); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++; if (req_rdy !== 1'b1 || sr_en !== 1'b0 || resp_val !== 1'b0) begin n_fail++; $display("FAIL mid_after_idle got rdy=%b en=%b val=%b exp 1 0 0", req_rdy, sr_en, resp_val); end
      @(negedge clk);
      n_tests++; if (resp_val !== 1'b0 || sr_en !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp got val=%b en=%b exp 0 0", resp_val, sr_en); end
      transact(8'd1, en_cnt, lat, q, z);
      n_tests++; if (q !== 8'h80 || lat !== 2) begin n_fail++; $display("FAIL mid_new_req got q=%h lat=%0d exp 80 2", q, lat); end
      finish_resp();
   endtask

   task automatic test_back_to_back();
      int en_cnt, lat;
      logic [7:0] q;
      logic z;
      do_reset(8'h01);
      transact(8'd1, en_cnt, lat, q, z);
      n_tests++; if (q !== 8'h80) begin n_fail++; $display("FAIL b2b_first_q got=%h exp=80", q); end
      req_val  = 1'b1;
      req_cnt  = 8'd1;
      resp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_rdy = 1'b0;
      n_tests++; if (req_rdy !== 1'b1 || sr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_not_same_cycle got rdy=%b en=%b exp 1 0", req_rdy, sr_en); end
      @(posedge clk);
      @(negedge clk);
      req_val = 1'b0;
      n_tests++; if (sr_en !== 1'b1) begin n_fail++; $display("FAIL b2b_shift got en=%b exp=1", sr_en); end
      @(negedge clk);
      n_tests++; if (resp_val !== 1'b1 || resp_q !== 8'h40) begin n_fail++; $display("FAIL b2b_second got val=%b q=%h exp 1 40", resp_val, resp_q); end
      finish_resp();
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      seed_v   = 8'h01;
      req_val  = 1'b0;
      req_cnt  = '0;
      resp_rdy = 1'b0;
      test_reset();
      test_steps("cnt1",  8'h01, 8'd1, 8'h80, 1'b0);
      test_steps("cnt2",  8'h01, 8'd2, 8'h40, 1'b0);
      test_steps("seed3", 8'h03, 8'd2, 8'h80, 1'b0);
      test_steps("cnt0",  8'h5A, 8'd0, 8'h5A, 1'b0);
      test_steps("zero",  8'h00, 8'd5, 8'h00, 1'b1);
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
